// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor that computes (a - b) mod 2^WIDTH one bit per clock,
// LSB first, using a single difference/borrow cell with a registered borrow.
// This is the subtracting counterpart of the bit-serial full-adder datapath.
// Use it where area matters more than latency.
//
// An operation is accepted on a clock edge where start is high and the block
// is idle or presenting a result. Bits 0..WIDTH-1 are then processed on the
// following WIDTH edges. After the edge that processes the last bit, done
// pulses for one cycle. The result outputs update only at completion and
// otherwise hold their value.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   start  : request to begin an operation (ignored while busy)
//   a      : minuend, sampled only on the accepting edge
//   b      : subtrahend, sampled only on the accepting edge
//   busy   : high while bits are being processed (registered)
//   done   : one-cycle pulse, result valid and freshly updated (registered)
//   diff   : (a - b) mod 2^WIDTH of the last completed operation
//   borrow : final borrow-out of the last operation (1 iff a < b, unsigned)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Single-bit difference/borrow cell working on the current LSBs.
    logic a0;
    logic b0;
    logic d_bit;
    logic bout;
    logic last_bit;

    always_comb begin
        a0       = a_sh_q[0];
        b0       = b_sh_q[0];
        d_bit    = a0 ^ b0 ^ bin_q;
        bout     = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and datapath control. Every register holds its value unless
    // the current state explicitly updates it. As a result, diff/borrow stay
    // untouched through IDLE and through the BUSY phase of a later operation.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // The new bit enters at the MSB. After WIDTH shifts, bit 0
                // has travelled down to the LSB position.
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                bin_d  = bout;
                if (last_bit) begin
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                // A start seen while the result is presented chains directly
                // into the next operation, with no idle cycle in between.
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are decoded from the next state and then
        // registered. This keeps start from having a combinational path
        // to busy or done.
        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
